// File: rtl/ram_scan_reader_pkg.sv
// ram_scan_pkg: shared state type and default geometry for the RAM scan reader
package ram_scan_pkg;
  typedef enum logic {WAIT_READ, HOLD} scan_state_t;
  localparam int DEF_ADDR_WIDTH = 5;
  localparam int DEF_DATA_WIDTH = 4;
  localparam int DEF_READ_LATENCY = 2;
endpackage

// File: rtl/ram_scan_reader_step_timer.sv
// step_timer: free-running step counter with a one-cycle terminal-count pulse
module step_timer #(
  parameter int TICKS_PER_STEP = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);
  localparam int CW = $clog2(TICKS_PER_STEP);
  logic [CW-1:0] cnt;
  logic last;
  always_comb begin
    last = cnt == CW'(TICKS_PER_STEP - 1);
    tick = enable && last;
  end
  always_ff @(posedge clk) begin
    if (reset || !enable) cnt <= '0;
    else cnt <= last ? '0 : cnt + 1'b1;
  end
endmodule

// File: rtl/ram_scan_reader.sv
// ram_scan_reader: walks the RAM read port and latches each word into display registers
module ram_scan_reader
  import ram_scan_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int TICKS_PER_STEP = 50_000_000,
  parameter int READ_LATENCY = DEF_READ_LATENCY
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  step,
  output logic [ADDR_WIDTH-1:0] rd_address,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH-1:0] disp_address,
  output logic [DATA_WIDTH-1:0] disp_data,
  output logic                  disp_valid
);
  localparam int LW = $clog2(READ_LATENCY + 2);
  scan_state_t state, state_nx;
  logic [LW-1:0] lat;
  logic armed, tick, capture, advance;
  step_timer #(.TICKS_PER_STEP(TICKS_PER_STEP)) u_timer (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .tick(tick)
  );
  always_comb begin
    capture = state == WAIT_READ && lat == LW'(READ_LATENCY);
    advance = state == HOLD && (enable ? tick : step);
    state_nx = capture ? HOLD : advance ? WAIT_READ : state;
  end
  // armed holds the counter still on the first edge out of reset, making it that edge's E0
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= WAIT_READ;
      lat <= '0;
      armed <= 1'b0;
      rd_address <= '0;
      disp_address <= '0;
      disp_data <= '0;
      disp_valid <= 1'b0;
    end else begin
      state <= state_nx;
      armed <= 1'b1;
      if (advance) begin
        rd_address <= rd_address + 1'b1;
        lat <= '0;
      end else if (state == WAIT_READ && armed && !capture) begin
        lat <= lat + 1'b1;
      end
      if (capture) begin
        disp_address <= rd_address;
        disp_data <= rd_data;
        disp_valid <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_ram_scan_reader.sv
// tb_ram_scan_reader: directed checks of capture timing, auto/manual scan, wrap and reset
module tb_ram_scan_reader;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  logic step = 1'b0;
  logic [4:0] rd_address, disp_address, addr_q;
  logic [3:0] rd_data, disp_data;
  logic disp_valid;
  logic [3:0] mem [32];
  int passed = 0;
  int total = 0;
  ram_scan_reader #(.ADDR_WIDTH(5), .DATA_WIDTH(4), .TICKS_PER_STEP(8), .READ_LATENCY(2)) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .step(step),
    .rd_address(rd_address),
    .rd_data(rd_data),
    .disp_address(disp_address),
    .disp_data(disp_data),
    .disp_valid(disp_valid)
  );
  always #5 clk = ~clk;
  initial for (int i = 0; i < 32; i++) mem[i] = i[3:0] ^ 4'hA;
  always @(posedge clk) begin
    addr_q <= rd_address;
    rd_data <= mem[addr_q];
  end
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    reset = 1'b1;
    cyc(2);
    total++; if ({rd_address, disp_address, disp_data, disp_valid} !== 15'd0) $display("FAIL reset_outputs got %h want 0", {rd_address, disp_address, disp_data, disp_valid}); else passed++;
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc(1);
      total++; if (disp_valid !== 1'b0) $display("FAIL reset_valid_early edge %0d got %b want 0", k, disp_valid); else passed++;
    end
    cyc(1);
    total++; if ({disp_valid, disp_address, disp_data} !== {1'b1, 5'd0, 4'hA}) $display("FAIL reset_first_capture got %b/%h/%h want 1/00/a", disp_valid, disp_address, disp_data); else passed++;
  endtask
  task automatic test_auto_scan;
    enable = 1'b1;
    cyc(7);
    total++; if (rd_address !== 5'd0) $display("FAIL auto_before_step got %h want 00", rd_address); else passed++;
    cyc(1);
    total++; if (rd_address !== 5'd1) $display("FAIL auto_step1 got %h want 01", rd_address); else passed++;
    cyc(2);
    total++; if ({disp_address, disp_data} !== {5'd0, 4'hA}) $display("FAIL auto_hold_display got %h/%h want 00/a", disp_address, disp_data); else passed++;
    cyc(1);
    total++; if ({disp_address, disp_data} !== {5'd1, 4'hB}) $display("FAIL auto_capture1 got %h/%h want 01/b", disp_address, disp_data); else passed++;
    cyc(4);
    total++; if (rd_address !== 5'd1) $display("FAIL auto_period got %h want 01", rd_address); else passed++;
    cyc(1);
    total++; if (rd_address !== 5'd2) $display("FAIL auto_step2 got %h want 02", rd_address); else passed++;
    cyc(3);
    total++; if ({disp_address, disp_data} !== {5'd2, 4'h8}) $display("FAIL auto_capture2 got %h/%h want 02/8", disp_address, disp_data); else passed++;
  endtask
  task automatic test_wrap;
    cyc(5 + 28 * 8);
    total++; if (rd_address !== 5'd31) $display("FAIL wrap_at_31 got %h want 1f", rd_address); else passed++;
    cyc(3);
    total++; if ({disp_address, disp_data} !== {5'd31, 4'h5}) $display("FAIL wrap_capture31 got %h/%h want 1f/5", disp_address, disp_data); else passed++;
    cyc(5);
    total++; if (rd_address !== 5'd0) $display("FAIL wrap_to_0 got %h want 00", rd_address); else passed++;
    cyc(3);
    total++; if ({disp_address, disp_data} !== {5'd0, 4'hA}) $display("FAIL wrap_capture0 got %h/%h want 00/a", disp_address, disp_data); else passed++;
  endtask
  task automatic test_manual;
    enable = 1'b0;
    cyc(100);
    total++; if ({rd_address, disp_address, disp_data} !== {5'd0, 5'd0, 4'hA}) $display("FAIL manual_idle got %h/%h/%h want 00/00/a", rd_address, disp_address, disp_data); else passed++;
    step = 1'b1;
    cyc(1);
    total++; if (rd_address !== 5'd1) $display("FAIL manual_step got %h want 01", rd_address); else passed++;
    cyc(1);
    step = 1'b0;
    total++; if (rd_address !== 5'd1) $display("FAIL manual_step_ignored got %h want 01", rd_address); else passed++;
    total++; if (disp_address !== 5'd0) $display("FAIL manual_no_flicker got %h want 00", disp_address); else passed++;
    cyc(2);
    total++; if ({disp_address, disp_data} !== {5'd1, 4'hB}) $display("FAIL manual_capture got %h/%h want 01/b", disp_address, disp_data); else passed++;
    cyc(5);
    total++; if (rd_address !== 5'd1) $display("FAIL manual_not_queued got %h want 01", rd_address); else passed++;
  endtask
  task automatic test_reset_mid;
    for (int k = 0; k < 8; k++) begin
      step = 1'b1;
      cyc(1);
      step = 1'b0;
      cyc(3);
    end
    step = 1'b1;
    cyc(1);
    step = 1'b0;
    total++; if (rd_address !== 5'h0A) $display("FAIL mid_setup got %h want 0a", rd_address); else passed++;
    reset = 1'b1;
    cyc(1);
    total++; if ({rd_address, disp_valid, disp_data, disp_address} !== 15'd0) $display("FAIL mid_reset got %h/%b/%h/%h want 00/0/0/00", rd_address, disp_valid, disp_data, disp_address); else passed++;
    reset = 1'b0;
    cyc(4);
    total++; if ({disp_valid, disp_data} !== {1'b1, 4'hA}) $display("FAIL mid_recapture got %b/%h want 1/a", disp_valid, disp_data); else passed++;
  endtask
  task automatic test_enable_toggle;
    enable = 1'b1;
    cyc(5);
    enable = 1'b0;
    cyc(20);
    total++; if (rd_address !== 5'd0) $display("FAIL toggle_paused got %h want 00", rd_address); else passed++;
    enable = 1'b1;
    cyc(7);
    total++; if (rd_address !== 5'd0) $display("FAIL toggle_early got %h want 00", rd_address); else passed++;
    cyc(1);
    total++; if (rd_address !== 5'd1) $display("FAIL toggle_advance got %h want 01", rd_address); else passed++;
  endtask
  initial begin
    #1;
    test_reset;
    test_auto_scan;
    test_wrap;
    test_manual;
    test_reset_mid;
    test_enable_toggle;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
